// File: rtl/sext_pipe_pkg.sv
// rtl/sext_pipe_pkg.sv - mode encodings and parameter sanity check for sext_pipe
package sext_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'd0,
    MODE_SIGN = 2'd1,
    MODE_SATU = 2'd2,
    MODE_SATS = 2'd3
  } sext_mode_e;

  function automatic bit params_ok(int in_w, int out_w, int nch, int stages);
    return (in_w >= 2) && (out_w >= 2) && (nch >= 1) && (stages >= 1) && (stages <= 4);
  endfunction

endpackage

// File: rtl/sext_resize_lane.sv
// rtl/sext_resize_lane.sv - combinational single-lane extend/truncate/saturate converter
module sext_resize_lane
  import sext_pipe_pkg::*;
#(
  parameter int INWIDTH  = 16,
  parameter int OUTWIDTH = 32
) (
  input  logic [INWIDTH-1:0]  lane_in,
  input  logic [1:0]          mode,
  output logic [OUTWIDTH-1:0] lane_out,
  output logic                sat
);

  if (OUTWIDTH >= INWIDTH) begin : g_widen
    always_comb begin
      sat = 1'b0;
      if (mode == MODE_SIGN || mode == MODE_SATS)
        lane_out = OUTWIDTH'($signed(lane_in));
      else
        lane_out = OUTWIDTH'(lane_in);
    end
  end else begin : g_narrow
    logic [OUTWIDTH-1:0]         low;
    logic [OUTWIDTH-1:0]         max_s;
    logic [OUTWIDTH-1:0]         min_s;
    // Bits that must all match the kept sign bit for a signed value to fit.
    logic [INWIDTH-OUTWIDTH:0]   top;
    logic                        over_u;
    logic                        over_s;

    assign low    = lane_in[OUTWIDTH-1:0];
    assign top    = lane_in[INWIDTH-1:OUTWIDTH-1];
    assign over_u = |lane_in[INWIDTH-1:OUTWIDTH];
    assign over_s = !((&top) || !(|top));
    assign max_s  = {1'b0, {(OUTWIDTH-1){1'b1}}};
    assign min_s  = ~max_s;

    always_comb begin
      lane_out = low;
      sat      = 1'b0;
      case (mode)
        MODE_SATU: begin
          if (over_u) begin
            lane_out = '1;
            sat      = 1'b1;
          end
        end
        MODE_SATS: begin
          if (over_s) begin
            lane_out = lane_in[INWIDTH-1] ? min_s : max_s;
            sat      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sext_pipe.sv
// rtl/sext_pipe.sv - multi-lane width converter behind an elastic valid/ready register pipeline
module sext_pipe
  import sext_pipe_pkg::*;
#(
  parameter int INWIDTH  = 16,
  parameter int OUTWIDTH = 32,
  parameter int NCH      = 1,
  parameter int STAGES   = 1,
  parameter int CNTW     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NCH*INWIDTH-1:0]   in_data,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NCH*OUTWIDTH-1:0]  out_data,
  output logic [NCH-1:0]           out_sat,
  output logic [CNTW-1:0]          sat_count,
  input  logic                     sat_clr
);

  localparam int DW = NCH*OUTWIDTH + NCH;

  if (!params_ok(INWIDTH, OUTWIDTH, NCH, STAGES)) begin : g_bad_params
    $fatal(1, "sext_pipe: widths must be >= 2, NCH >= 1, STAGES in 1..4");
  end

  logic [NCH*OUTWIDTH-1:0] conv_data;
  logic [NCH-1:0]          conv_sat;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    sext_resize_lane #(
      .INWIDTH (INWIDTH),
      .OUTWIDTH(OUTWIDTH)
    ) u_lane (
      .lane_in (in_data[k*INWIDTH +: INWIDTH]),
      .mode    (in_mode),
      .lane_out(conv_data[k*OUTWIDTH +: OUTWIDTH]),
      .sat     (conv_sat[k])
    );
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] rdy;
  logic [DW-1:0]     dat [STAGES];
  logic              rdy_acc;

  // A stage may load when empty or when everything downstream can move.
  always_comb begin
    rdy     = '0;
    rdy_acc = out_ready;
    for (int i = STAGES-1; i >= 0; i--) begin
      rdy_acc = !vld[i] || rdy_acc;
      rdy[i]  = rdy_acc;
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic          v_q;
    logic [DW-1:0] d_q;
    logic          v_prev;
    logic [DW-1:0] d_prev;

    if (i == 0) begin : g_head
      assign v_prev = in_valid;
      assign d_prev = {conv_sat, conv_data};
    end else begin : g_body
      assign v_prev = vld[i-1];
      assign d_prev = dat[i-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (rdy[i]) begin
        v_q <= v_prev;
        d_q <= d_prev;
      end
    end

    assign vld[i] = v_q;
    assign dat[i] = d_q;
  end

  assign in_ready              = rdy[0];
  assign out_valid             = vld[STAGES-1];
  assign {out_sat, out_data}   = dat[STAGES-1];

  logic count_ev;
  assign count_ev = out_valid && out_ready && (|out_sat);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      sat_count <= '0;
    else if (sat_clr)
      sat_count <= count_ev ? CNTW'(1) : '0;
    else if (count_ev && sat_count != '1)
      sat_count <= sat_count + CNTW'(1);
  end

endmodule

// File: doc/sext_pipe.md
Name: sext_pipe

Overview:
Parametrised, multi-channel width converter; successor to the combinational sign-extend macrocell.
- Widens (zero/sign extend) or narrows (truncate/saturate) NCH independent lanes.
- Mode is selected per transfer; data passes through an elastic valid/ready pipeline of STAGES register slices.
- Sits between datapath macrocells whose operand widths differ; reports per-lane saturation and keeps a saturating event counter.

Parameters:
INWIDTH, 16, input lane width (>=2)
OUTWIDTH, 32, output lane width (>=2); may be less than, equal to, or greater than INWIDTH
NCH, 1, number of lanes (>=1)
STAGES, 1, pipeline register slices (1..4)
CNTW, 16, saturation counter width

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream data valid
in_ready  output  1  block can accept this cycle
in_data  input  NCH*INWIDTH  lane k at bits [k*INWIDTH +: INWIDTH]
in_mode  input  2  0=zero/trunc, 1=sign/trunc, 2=sat unsigned, 3=sat signed
out_valid  output  1  output data valid
out_ready  input  1  downstream accepts
out_data  output  NCH*OUTWIDTH  lane k at bits [k*OUTWIDTH +: OUTWIDTH]
out_sat  output  NCH  per-lane saturation flag, qualified by out_valid
sat_count  output  CNTW  transfers with any out_sat set, saturating
sat_clr  input  1  synchronous clear of sat_count

Behaviour:
- Reset (async assert, sync deassert internally not required): all stage valids 0, out_valid 0, out_data 0, out_sat 0, sat_count 0; in_ready 1 from first cycle after reset release.
- Handshake: a transfer occurs when valid&&ready on a side. out_valid may not drop and out_data/out_sat must stay stable until out_ready.
- Pipeline: stage i ready = !valid_i || ready_{i+1}; last stage sees out_ready. in_ready = stage-0 ready. No combinational path in_valid->out_valid; in_ready is combinational from out_ready (bubble-collapsing).
- Latency exactly STAGES cycles from accepted input to out_valid with out_ready held high. Throughput 1 transfer/cycle.
- Conversion is computed combinationally before stage 0 and carried as data, along with the sat flags.
- Widening (OUTWIDTH>=INWIDTH): mode 0/2 zero-extend; mode 1/3 sign-extend from bit INWIDTH-1; out_sat=0.
- Narrowing (OUTWIDTH<INWIDTH), mode 0/1: keep low OUTWIDTH bits; out_sat=0.
- Narrowing, mode 2: input is unsigned. If any bit above OUTWIDTH-1 is set, output all ones and set sat; otherwise output the low bits.
- Narrowing, mode 3: input is signed. If bits [INWIDTH-1:OUTWIDTH-1] are not all equal, output 0 followed by all ones (max) when the input MSB=0, or 1 followed by zeros (min) when MSB=1, and set sat; otherwise output the low bits.
- sat_count:
  - increments by 1 on each output transfer with |out_sat; holds at all-ones.
  - sat_clr alone sets it to 0.
  - sat_clr coincident with a counting transfer sets it to 1.
- Reset mid-stream discards all in-flight data; no partial transfer is emitted.

Decomposition:
- Package sext_pipe_pkg: mode constants MODE_ZERO=2'd0, MODE_SIGN=2'd1, MODE_SATU=2'd2, MODE_SATS=2'd3; parameter-range checks (simulation-only error display and $finish for STAGES outside 1..4, widths <2).
- Sub-module sext_resize_lane: combinational single-lane converter (INWIDTH, OUTWIDTH; in, mode -> out, sat), instantiated NCH times via generate.
- Stage registers and counter live in the top level.

Test Plan:
- INWIDTH=8, OUTWIDTH=16, NCH=2, STAGES=2, out_ready=1:
  - in_data=16'h80_7F, mode 1 -> two cycles later out_data=32'hFF80_007F, out_sat=0.
  - Same input, mode 0 -> 32'h0080_007F.
- INWIDTH=16, OUTWIDTH=8, NCH=1, mode 3:
  - 16'h0123 -> 8'h7F, sat=1.
  - 16'hFF80 -> 8'h80, sat=0.
  - 16'h8000 -> 8'h80, sat=1.
  - After these three transfers, sat_count=2.
- Same config, mode 2:
  - 16'h00FF -> 8'hFF, sat=0.
  - 16'h0100 -> 8'hFF, sat=1.
  - Mode 0 on 16'h0100 -> 8'h00, sat=0.
- Backpressure, STAGES=2: stream 5 words with out_ready low for cycles 3-6.
  - in_ready deasserts after 2 words are held.
  - Output order and values are preserved; no duplicates or drops.
  - out_data is stable while stalled.
- sat_count: preset to all ones via CNTW=4 and 16 saturating transfers -> holds at 4'hF.
  - sat_clr coincident with a saturating transfer -> 1.
  - sat_clr alone -> 0.
- Assert reset_n low with 2 words in flight -> out_valid=0 and sat_count=0 immediately (asynchronously).
  - After release: in_ready=1 and no stale output appears.
